ld_power_sequencer: RTL

//  Sequences the laser-diode current driver: owns its SW_ON/LD_ON controls and walks it

---
 rtl/ld_seq_pkg.sv | 25 ++
 rtl/ld_seq_timer.sv | 28 ++
 rtl/ld_power_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ld_seq_pkg.sv
// rtl/ld_seq_pkg.sv - shared state codes, widths and timer sizing for the LD power sequencer
package ld_seq_pkg;

    localparam int IW_DEFAULT = 12;

    // Codes 6 and 7 are unused and fall into FAULT on the next cycle.
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_ON        = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } ld_state_e;

    // One timer serves every timed state, so it must hold the larger of the two spans.
    // The lower bound of 1 keeps the width non-zero for degenerate parameter values.
    function automatic int tmr_width(input int settle_cyc, input int tmo_cyc);
        int mx;
        mx = (settle_cyc > tmo_cyc) ? settle_cyc : tmo_cyc;
        if (mx < 1) mx = 1;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/ld_seq_timer.sv
// rtl/ld_seq_timer.sv - loadable saturating down-counter used for settle and ramp timeouts
module ld_seq_timer #(
    parameter int TW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [TW-1:0] load_val_i,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;

    // Load wins over counting; the count parks at zero instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ld_power_sequencer.sv
// rtl/ld_power_sequencer.sv - laser-diode driver power sequencer FSM with fault latching
module ld_power_sequencer
    import ld_seq_pkg::*;
#(
    parameter int IW           = IW_DEFAULT,
    parameter int SETTLE_CYC   = 1000,
    parameter int RAMP_TMO_CYC = 1500000
) (
    input  logic          CLK,
    input  logic          Clrn,
    input  logic          start,
    input  logic          stop,
    input  logic          fault_in,
    input  logic          fault_clr,
    input  logic [IW-1:0] I_target,
    input  logic [IW-1:0] I_fb,
    output logic          SW_ON,
    output logic          LD_ON,
    output logic          ready,
    output logic          busy,
    output logic          fault_latched,
    output logic [2:0]    state
);

    localparam int TW = tmr_width(SETTLE_CYC, RAMP_TMO_CYC);

    // The timer is loaded on the entry edge and the exit is taken on the edge that
    // sees zero, so loading N-1 gives exactly N cycles spent in the state.
    localparam int SETTLE_LD_I = (SETTLE_CYC   > 0) ? SETTLE_CYC - 1   : 0;
    localparam int TMO_LD_I    = (RAMP_TMO_CYC > 0) ? RAMP_TMO_CYC - 1 : 0;
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_LD_I);
    localparam logic [TW-1:0] TMO_LD    = TW'(TMO_LD_I);

    ld_state_e     state_q;
    ld_state_e     state_d;
    logic [IW-1:0] target_q;
    logic [IW-1:0] target_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_done;
    logic          up_reached;
    logic          down_reached;

    assign up_reached   = (I_fb >= target_q);
    assign down_reached = (I_fb == '0);

    // Next-state decision: fault_in first, then timeout, then stop, then start.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            ST_OFF: begin
                if (fault_in) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d = ST_OFF;
                end else if (start && !fault_latched && (I_target != '0)) begin
                    state_d  = ST_SETTLE;
                    target_d = I_target;
                end
            end
            ST_SETTLE: begin
                if (fault_in) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d = ST_OFF;
                end else if (tmr_done) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (fault_in) begin
                    state_d = ST_FAULT;
                end else if (tmr_done && !up_reached) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d = ST_RAMP_DOWN;
                end else if (up_reached) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (fault_in) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (fault_in) begin
                    state_d = ST_FAULT;
                end else if (down_reached) begin
                    state_d = ST_OFF;
                end else if (tmr_done) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !fault_in) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Reload the timer on every state change with the span of the state being entered.
    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        case (state_d)
            ST_SETTLE:    tmr_load_val = SETTLE_LD;
            ST_RAMP_UP:   tmr_load_val = TMO_LD;
            ST_RAMP_DOWN: tmr_load_val = TMO_LD;
            default:      tmr_load_val = '0;
        endcase
    end

    ld_seq_timer #(
        .TW (TW)
    ) u_timer (
        .clk_i      (CLK),
        .rst_ni     (Clrn),
        .load_i     (tmr_load),
        .en_i       (1'b1),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    // State, latched target and all outputs registered from the next state.
    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            state_q       <= ST_OFF;
            target_q      <= '0;
            SW_ON         <= 1'b0;
            LD_ON         <= 1'b0;
            ready         <= 1'b0;
            busy          <= 1'b0;
            fault_latched <= 1'b0;
            state         <= ST_OFF;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            SW_ON         <= (state_d == ST_SETTLE) || (state_d == ST_RAMP_UP) ||
                             (state_d == ST_ON)     || (state_d == ST_RAMP_DOWN);
            LD_ON         <= (state_d == ST_RAMP_UP) || (state_d == ST_ON);
            ready         <= (state_d == ST_ON);
            busy          <= (state_d == ST_SETTLE) || (state_d == ST_RAMP_UP) ||
                             (state_d == ST_RAMP_DOWN);
            fault_latched <= (state_d == ST_FAULT);
            state         <= state_d;
        end
    end

endmodule
